hdmi_island_scheduler: RTL and testbench
========================================

// Module: hdmi_island_scheduler
// PURPOSE
//  Sequences HDMI data islands in horizontal blanking and shares the packet slots among four packet sources.
//  Sources: ACR, audio sample, AVI infoframe, audio infoframe.
//  Per line it emits preamble/guard/packet phase strobes, a one-hot grant and a 5-bit packet bit counter.
//  Sits between the video timing generator and the data-island packet encoder/TERC4 mux in the HDMI tx path.
// PARAMETERS
//  HOFS     8   pixel clocks from the qualifying hsync edge to preamble start
//  MAX_PKTS 2   max packets per island (1..18)
//  PRE_LEN  8   preamble length, clocks
//  GRD_LEN  2   leading and trailing guard-band length, clocks
// PORTS
//  i_pixclk   in   1  pixel clock
//  i_rst_n    in   1  asynchronous active-low reset
//  i_enable   in   1  islands allowed; sampled only in IDLE
//  i_hSync    in   1  hsync (either polarity; the edge is used)
//  i_blank    in   1  1 = blanking interval
//  i_req      in   4  held-high requests: [0]ACR [1]audio [2]AVI [3]audio IF
//  o_grant    out  4  one-hot owner of the current packet; 0 outside PACKET
//  o_done     out  4  one-clock pulse on the last clock of the granted packet
//  o_phase    out  3  0 IDLE, 1 WAIT, 2 PRE, 3 LGUARD, 4 PACKET, 5 TGUARD
//  o_bit      out  5  clock index within the packet, 0..31; 0 outside PACKET
//  o_first    out  1  high throughout the first packet of an island
//  o_island   out  1  high from LGUARD through TGUARD inclusive
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, round-robin pointer selects AVI.
//  - Qualifying edge: a registered hsync change while i_blank=1.
//    - Only the first of each pair of changes qualifies, i.e. the leading edge of each line.
//    - The pair toggle clears when i_blank rises.
//  - IDLE -> WAIT on a qualifying edge when i_enable=1 and |i_req. Otherwise stay in IDLE.
//  - WAIT: runs HOFS clocks, then PRE.
//    - Arbitration happens on the last WAIT clock; if i_req is 0 there, go to IDLE instead of PRE.
//  - PRE runs PRE_LEN clocks, then LGUARD runs GRD_LEN clocks, then PACKET.
//  - PACKET lasts 32 clocks; o_bit counts 0..31.
//    - o_grant is registered at packet start and held for all 32 clocks.
//    - o_done equals o_grant at o_bit==31.
//  - Arbitration: a pending ACR always wins; else audio; else AVI/audio-IF by round-robin.
//    - The round-robin pointer flips only after an infoframe is granted.
//  - At o_bit==31: if another request is pending (sampled that clock, excluding the bit just done)
//    and fewer than MAX_PKTS packets have been sent, start the next PACKET with no gap.
//    Otherwise go to TGUARD.
//  - TGUARD runs GRD_LEN clocks, then IDLE. At most one island per line.
//  - Requesters drop i_req the clock after o_done. A request deasserted before grant is simply skipped.
//  - i_blank falling in WAIT..TGUARD aborts to IDLE on the next clock.
//    - All outputs go to 0, no o_done is issued, and the round-robin pointer is unchanged.
//  - i_enable low mid-island has no effect; the island completes.
//  - Asynchronous reset mid-island clears everything immediately.
//  - Counters saturate nowhere: WAIT/PRE/GUARD counters are 8-bit, packet count is 5-bit, all reload on entry.
// TESTING
//  - Reset, then blank=1 line, req=4'b0001, HOFS=8 -> PRE 9..16 clocks after edge, LGUARD 2, one 32-clk ACR packet.
//    Expect o_done=4'b0001 once, TGUARD 2, then IDLE.
//  - req=4'b1111, MAX_PKTS=2 -> packets ACR then audio, back-to-back; o_first only on the first.
//    Next line req=4'b1100 -> AVI, audio IF.
//  - req=4'b1100 held over 4 lines, MAX_PKTS=1 -> grants alternate AVI, IF, AVI, IF.
//  - i_blank falls at o_bit==10 of the first packet -> o_phase=0 and o_grant=0 next clock, no o_done.
//    Next line regrants the same source.
//  - i_enable=0 or req=0 at the edge -> o_phase stays 0 for the line. Second hsync change on the same line is ignored.
//  - i_rst_n low at o_bit==20 -> outputs 0 asynchronously; after release the FSM waits for the next qualifying edge.

Source files
------------

// File: rtl/hdmi_island_scheduler.sv
// Data-island sequencer for HDMI blanking: finds the leading hsync edge of each blanked line,
// runs WAIT/PRE/LGUARD/PACKET/TGUARD timing and shares packet slots among four sources.
module hdmi_island_scheduler #(
  parameter int HOFS     = 8,
  parameter int MAX_PKTS = 2,
  parameter int PRE_LEN  = 8,
  parameter int GRD_LEN  = 2
) (
  input  logic       i_pixclk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_hSync,
  input  logic       i_blank,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [3:0] o_done,
  output logic [2:0] o_phase,
  output logic [4:0] o_bit,
  output logic       o_first,
  output logic       o_island
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_PRE    = 3'd2,
    S_LGUARD = 3'd3,
    S_PACKET = 3'd4,
    S_TGUARD = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(HOFS - 1);
  localparam logic [7:0] PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [7:0] GRD_LAST  = 8'(GRD_LEN - 1);
  localparam logic [4:0] MAX_CNT   = 5'(MAX_PKTS);

  state_t     state_q,  state_d;
  logic [7:0] cnt_q,    cnt_d;
  logic [4:0] bit_q,    bit_d;
  logic [4:0] pkt_q,    pkt_d;
  logic [3:0] grant_q,  grant_d;
  logic [3:0] next_q,   next_d;
  logic [3:0] done_q,   done_d;
  logic       first_q,  first_d;
  logic       island_q, island_d;
  logic       rr_q,     rr_d;
  logic       pair_q,   pair_d;
  logic       hs1_q,    hs2_q;
  logic       blank_q;

  logic       chg_s;
  logic       blank_rise_s;
  logic       qual_s;
  logic [3:0] masked_s;

  // Fixed priority ACR > audio, then AVI/audio-IF by the round-robin pointer (rr=0 favours AVI).
  function automatic logic [3:0] arb(input logic [3:0] req, input logic rr);
    logic [3:0] g;
    g = 4'b0000;
    if (req[0]) begin
      g = 4'b0001;
    end else if (req[1]) begin
      g = 4'b0010;
    end else if (req[2] && req[3]) begin
      g = rr ? 4'b1000 : 4'b0100;
    end else if (req[2]) begin
      g = 4'b0100;
    end else if (req[3]) begin
      g = 4'b1000;
    end else begin
      g = 4'b0000;
    end
    return g;
  endfunction

  // Leading-edge qualification: every other hsync change in blanking, re-armed by blank rising.
  always_comb begin
    chg_s        = hs1_q ^ hs2_q;
    blank_rise_s = i_blank & ~blank_q;
    qual_s       = chg_s & i_blank & (blank_rise_s | ~pair_q);
    masked_s     = i_req & ~grant_q;
    pair_d       = pair_q;
    if (chg_s && i_blank) begin
      pair_d = blank_rise_s ? 1'b1 : ~pair_q;
    end else if (blank_rise_s) begin
      pair_d = 1'b0;
    end else begin
      pair_d = pair_q;
    end
  end

  // Island sequencing and packet arbitration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    pkt_d    = pkt_q;
    grant_d  = grant_q;
    next_d   = next_q;
    done_d   = 4'b0000;
    first_d  = first_q;
    island_d = island_q;
    rr_d     = rr_q;
    case (state_q)
      S_IDLE: begin
        if (qual_s && i_enable && (i_req != 4'b0000)) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          if (i_req != 4'b0000) begin
            state_d = S_PRE;
            cnt_d   = PRE_LAST;
            next_d  = arb(i_req, rr_q);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d  = S_LGUARD;
          cnt_d    = GRD_LAST;
          island_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LGUARD: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PACKET;
          bit_d   = 5'd0;
          grant_d = next_q;
          first_d = 1'b1;
          pkt_d   = 5'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PACKET: begin
        if (bit_q == 5'd31) begin
          // o_done is already out this clock, so the packet counts as delivered.
          if ((grant_q & 4'b1100) != 4'b0000) begin
            rr_d = ~rr_q;
          end else begin
            rr_d = rr_q;
          end
          if ((masked_s != 4'b0000) && (pkt_q < MAX_CNT)) begin
            grant_d = arb(masked_s, rr_q);
            bit_d   = 5'd0;
            first_d = 1'b0;
            pkt_d   = pkt_q + 5'd1;
          end else begin
            state_d = S_TGUARD;
            cnt_d   = GRD_LAST;
            grant_d = 4'b0000;
            bit_d   = 5'd0;
            first_d = 1'b0;
          end
        end else begin
          bit_d  = bit_q + 5'd1;
          done_d = (bit_q == 5'd30) ? grant_q : 4'b0000;
        end
      end
      S_TGUARD: begin
        if (cnt_q == 8'd0) begin
          state_d  = S_IDLE;
          island_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        grant_d  = 4'b0000;
        bit_d    = 5'd0;
        first_d  = 1'b0;
        island_d = 1'b0;
      end
    endcase
    // Blanking ending early kills the island; rr_d is left alone so only delivered infoframes move it.
    if ((state_q != S_IDLE) && !i_blank) begin
      state_d  = S_IDLE;
      cnt_d    = 8'd0;
      bit_d    = 5'd0;
      grant_d  = 4'b0000;
      done_d   = 4'b0000;
      first_d  = 1'b0;
      island_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 5'd0;
      pkt_q    <= 5'd0;
      grant_q  <= 4'b0000;
      next_q   <= 4'b0000;
      done_q   <= 4'b0000;
      first_q  <= 1'b0;
      island_q <= 1'b0;
      rr_q     <= 1'b0;
      pair_q   <= 1'b0;
      hs1_q    <= 1'b0;
      hs2_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      pkt_q    <= pkt_d;
      grant_q  <= grant_d;
      next_q   <= next_d;
      done_q   <= done_d;
      first_q  <= first_d;
      island_q <= island_d;
      rr_q     <= rr_d;
      pair_q   <= pair_d;
      hs1_q    <= i_hSync;
      hs2_q    <= hs1_q;
      blank_q  <= i_blank;
    end
  end

  assign o_phase  = state_q;
  assign o_grant  = grant_q;
  assign o_done   = done_q;
  assign o_bit    = bit_q;
  assign o_first  = first_q;
  assign o_island = island_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler: each island's expected per-clock outputs are generated as a
// timeline from the packet list (priority order, round-robin infoframes, MAX_PKTS cap).
module tb_hdmi_island_scheduler;

  localparam int HOFS     = 8;
  localparam int MAX_PKTS = 2;
  localparam int PRE_LEN  = 8;
  localparam int GRD_LEN  = 2;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] gr;
    logic [3:0] dn;
    logic [4:0] bt;
    logic       fi;
    logic       is;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_enable;
  logic       i_hSync;
  logic       i_blank;
  logic [3:0] i_req;
  logic [3:0] o_grant;
  logic [3:0] o_done;
  logic [2:0] o_phase;
  logic [4:0] o_bit;
  logic       o_first;
  logic       o_island;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_rr     = 1'b0;
  exp_t exp_q[$];

  wire [17:0] outs = {o_phase, o_grant, o_done, o_bit, o_first, o_island};

  hdmi_island_scheduler #(
    .HOFS(HOFS), .MAX_PKTS(MAX_PKTS), .PRE_LEN(PRE_LEN), .GRD_LEN(GRD_LEN)
  ) dut (
    .i_pixclk(clk),
    .i_rst_n (rst_n),
    .i_enable(i_enable),
    .i_hSync (i_hSync),
    .i_blank (i_blank),
    .i_req   (i_req),
    .o_grant (o_grant),
    .o_done  (o_done),
    .o_phase (o_phase),
    .o_bit   (o_bit),
    .o_first (o_first),
    .o_island(o_island)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then compare {phase,grant,done,bit,first,island} with the timeline.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'(18'd0);
    chk("ph|gr|dn|bit|first|island", 32'(outs), 32'(e));
    if ((e.dn & 4'b1100) != 4'b0000) m_rr = ~m_rr;
  endtask

  task automatic build_island(input logic [3:0] req);
    int   own[$];
    exp_t e;
    if (req[0]) own.push_back(0);
    if (req[1]) own.push_back(1);
    if (!m_rr) begin
      if (req[2]) own.push_back(2);
      if (req[3]) own.push_back(3);
    end else begin
      if (req[3]) own.push_back(3);
      if (req[2]) own.push_back(2);
    end
    while (own.size() > MAX_PKTS) void'(own.pop_back());
    e = '0; e.ph = 3'd1;
    repeat (HOFS) exp_q.push_back(e);
    e.ph = 3'd2;
    repeat (PRE_LEN) exp_q.push_back(e);
    e.ph = 3'd3; e.is = 1'b1;
    repeat (GRD_LEN) exp_q.push_back(e);
    foreach (own[p]) begin
      for (int b = 0; b < 32; b++) begin
        e.ph = 3'd4;
        e.gr = 4'b0001 << own[p];
        e.bt = 5'(b);
        e.fi = (p == 0);
        e.dn = (b == 31) ? e.gr : 4'b0000;
        exp_q.push_back(e);
      end
    end
    e = '0; e.ph = 3'd5; e.is = 1'b1;
    repeat (GRD_LEN) exp_q.push_back(e);
  endtask

  // One line: active video, blanking, hsync pulse (two changes), optional abort or reset.
  task automatic run_line(input logic [3:0] req, input logic en, input int abort_j, input int rst_j);
    i_blank = 1'b0; i_req = req; i_enable = 1'b1;
    repeat (6) step();
    i_blank = 1'b1;
    repeat (3) step();
    i_enable = en;
    i_hSync  = ~i_hSync;
    exp_q.push_back(exp_t'(18'd0));
    if (en && (req != 4'b0000)) build_island(req);
    for (int j = 0; j < 200; j++) begin
      step();
      if (j == 1) i_enable = en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (j == 9) i_hSync = ~i_hSync;
      if (j == abort_j) begin
        i_blank = 1'b0;
        exp_q.delete();
      end
      if (j == rst_j) begin
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'(outs), 32'd0);
        i_blank = 1'b0; i_hSync = 1'b0; m_rr = 1'b0;
        exp_q.delete();
        repeat (3) step();
        rst_n = 1'b1;
      end
      if (j > 12 && exp_q.size() == 0) break;
    end
    chk("line_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int lead;
    rst_n = 1'b0; i_enable = 1'b0; i_hSync = 1'b0; i_blank = 1'b0; i_req = 4'b0000;
    #12;
    chk("reset_outputs", 32'(outs), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) step();

    lead = 1 + HOFS + PRE_LEN + GRD_LEN;
    run_line(4'b0001, 1'b1, -1, -1);
    run_line(4'b1111, 1'b1, -1, -1);
    run_line(4'b1100, 1'b1, -1, -1);
    repeat (4) run_line(4'b1110, 1'b1, -1, -1);
    run_line(4'b1100, 1'b1, lead + 10, -1);
    run_line(4'b1100, 1'b1, -1, -1);
    run_line(4'b1111, 1'b0, -1, -1);
    run_line(4'b0000, 1'b1, -1, -1);
    run_line(4'b1010, 1'b1, -1, lead + 20);
    run_line(4'b1000, 1'b1, -1, -1);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] r;
      logic       en;
      int         ab;
      r  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, lead + 40);
      run_line(r, en, ab, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
